// File: rtl/sh_bus_arbiter.sv
// sh_bus_arbiter: shares one memory port between two SH7604-style bus masters.
// Round-robin arbitration with a per-region wait-state counter (ROM = A[26:14]==0).
// Optional build macro SH_ARB_LOCK_EN adds M0_LOCK/M1_LOCK bus locking
// (the lock holder keeps the bus for read-modify-write sequences such as TAS.B).
module sh_bus_arbiter #(
    parameter int unsigned ROM_WAIT = 2,
    parameter int unsigned RAM_WAIT = 1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        CE,
    input  logic        M0_REQ,
    input  logic [26:0] M0_A,
    input  logic [31:0] M0_DO,
    input  logic [3:0]  M0_WE,
    output logic [31:0] M0_DI,
    output logic        M0_WAIT,
    input  logic        M1_REQ,
    input  logic [26:0] M1_A,
    input  logic [31:0] M1_DO,
    input  logic [3:0]  M1_WE,
    output logic [31:0] M1_DI,
    output logic        M1_WAIT,
`ifdef SH_ARB_LOCK_EN
    input  logic        M0_LOCK,
    input  logic        M1_LOCK,
`endif
    output logic [26:0] MEM_A,
    output logic [31:0] MEM_DO,
    output logic [3:0]  MEM_WE,
    output logic        MEM_RD,
    input  logic [31:0] MEM_DI,
    output logic [1:0]  GNT
);

    localparam int unsigned AW = 27;
    localparam int unsigned DW = 32;
    localparam int unsigned BW = 4;
    localparam int unsigned CW = 4;

    // Wait counts must fit the 4-bit counter.
    if (ROM_WAIT > 15 || RAM_WAIT > 15) begin : g_param_check
        $error("sh_bus_arbiter: ROM_WAIT and RAM_WAIT must be in 0..15");
    end

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [1:0]      gnt_q, gnt_d;
    logic            last_q, last_d;      // 1 = M1 owned the previous access
    logic [AW-1:0]   mem_a_q, mem_a_d;
    logic [DW-1:0]   mem_do_q, mem_do_d;
    logic [BW-1:0]   mem_we_q, mem_we_d;
    logic            mem_rd_q, mem_rd_d;
    logic [DW-1:0]   m0_di_q, m0_di_d;
    logic [DW-1:0]   m1_di_q, m1_di_d;
`ifdef SH_ARB_LOCK_EN
    logic            lock_q, lock_d;
    logic            lock_m1_q, lock_m1_d;
    logic            gnt_lock;
`endif

    logic            req_any;
    logic            lock_hold;
    logic            pick_m1;
    logic [AW-1:0]   sel_a;
    logic [DW-1:0]   sel_do;
    logic [BW-1:0]   sel_we;
    logic            rom_hit;

    // Choose the next owner: locked master first, then round-robin on ties.
    always_comb begin : arbitration
        req_any   = M0_REQ | M1_REQ;
        lock_hold = 1'b0;
`ifdef SH_ARB_LOCK_EN
        lock_hold = lock_q & (lock_m1_q ? M1_REQ : M0_REQ);
`endif
        if (lock_hold) begin
`ifdef SH_ARB_LOCK_EN
            pick_m1 = lock_m1_q;
`else
            pick_m1 = 1'b0;
`endif
        end else if (M0_REQ && M1_REQ) begin
            pick_m1 = ~last_q;
        end else begin
            pick_m1 = M1_REQ;
        end
        sel_a   = pick_m1 ? M1_A  : M0_A;
        sel_do  = pick_m1 ? M1_DO : M0_DO;
        sel_we  = pick_m1 ? M1_WE : M0_WE;
        rom_hit = (sel_a[26:14] == 13'd0);
    end

    // State and datapath registers; everything holds while CE is low.
    always_ff @(posedge CLK) begin : state_reg
        if (RST) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            gnt_q    <= '0;
            last_q   <= 1'b1;
            mem_a_q  <= '0;
            mem_do_q <= '0;
            mem_we_q <= '0;
            mem_rd_q <= 1'b0;
            m0_di_q  <= '0;
            m1_di_q  <= '0;
`ifdef SH_ARB_LOCK_EN
            lock_q    <= 1'b0;
            lock_m1_q <= 1'b0;
`endif
        end else if (CE) begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            gnt_q    <= gnt_d;
            last_q   <= last_d;
            mem_a_q  <= mem_a_d;
            mem_do_q <= mem_do_d;
            mem_we_q <= mem_we_d;
            mem_rd_q <= mem_rd_d;
            m0_di_q  <= m0_di_d;
            m1_di_q  <= m1_di_d;
`ifdef SH_ARB_LOCK_EN
            lock_q    <= lock_d;
            lock_m1_q <= lock_m1_d;
`endif
        end
    end

    // Next-state logic: IDLE -> ACCESS on any request, ACCESS until the count expires, one DONE cycle.
    always_comb begin : next_state
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (req_any) state_d = S_ACCESS;
            S_ACCESS: if (cnt_q == '0) state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Datapath next values: latch on grant, count waits, capture read data, release in DONE.
    always_comb begin : datapath_next
        cnt_d    = cnt_q;
        gnt_d    = gnt_q;
        last_d   = last_q;
        mem_a_d  = mem_a_q;
        mem_do_d = mem_do_q;
        mem_we_d = mem_we_q;
        mem_rd_d = mem_rd_q;
        m0_di_d  = m0_di_q;
        m1_di_d  = m1_di_q;
`ifdef SH_ARB_LOCK_EN
        lock_d    = lock_q;
        lock_m1_d = lock_m1_q;
        gnt_lock  = gnt_q[1] ? M1_LOCK : M0_LOCK;
`endif
        case (state_q)
            S_IDLE: begin
`ifdef SH_ARB_LOCK_EN
                // Lock owner no longer requesting: fall back to round-robin.
                if (lock_q && !lock_hold) lock_d = 1'b0;
`endif
                if (req_any) begin
                    mem_a_d  = sel_a;
                    mem_do_d = sel_do;
                    mem_we_d = sel_we;
                    mem_rd_d = (sel_we == '0);
                    cnt_d    = rom_hit ? CW'(ROM_WAIT) : CW'(RAM_WAIT);
                    gnt_d    = pick_m1 ? 2'b10 : 2'b01;
                end
            end
            S_ACCESS: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    if (mem_rd_q) begin
                        if (gnt_q[1]) m1_di_d = MEM_DI;
                        else          m0_di_d = MEM_DI;
                    end
                    mem_we_d = '0;
                    mem_rd_d = 1'b0;
                end
            end
            S_DONE: begin
                mem_we_d = '0;
                mem_rd_d = 1'b0;
                gnt_d    = '0;
                last_d   = gnt_q[1];
`ifdef SH_ARB_LOCK_EN
                if (gnt_lock) begin
                    last_d    = last_q;
                    lock_d    = 1'b1;
                    lock_m1_d = gnt_q[1];
                end else begin
                    lock_d = 1'b0;
                end
`endif
            end
            default: ;
        endcase
    end

    // Outputs: WAIT drops only in the owner's DONE cycle; everything else comes from registers.
    always_comb begin : outputs
        M0_WAIT = M0_REQ & ~((state_q == S_DONE) & gnt_q[0]);
        M1_WAIT = M1_REQ & ~((state_q == S_DONE) & gnt_q[1]);
        M0_DI   = m0_di_q;
        M1_DI   = m1_di_q;
        MEM_A   = mem_a_q;
        MEM_DO  = mem_do_q;
        MEM_WE  = mem_we_q;
        MEM_RD  = mem_rd_q;
        GNT     = gnt_q;
    end

endmodule

// File: tb/tb_sh_bus_arbiter.sv
// Testbench for sh_bus_arbiter: directed accesses with a scoreboard of expected completions.
// Build with +define+SH_ARB_LOCK_EN to include the bus-lock sequence.
module tb_sh_bus_arbiter;

    logic        CLK, RST, CE;
    logic        M0_REQ, M1_REQ;
    logic [26:0] M0_A, M1_A;
    logic [31:0] M0_DO, M1_DO;
    logic [3:0]  M0_WE, M1_WE;
    logic [31:0] M0_DI, M1_DI;
    logic        M0_WAIT, M1_WAIT;
`ifdef SH_ARB_LOCK_EN
    logic        M0_LOCK, M1_LOCK;
`endif
    logic [26:0] MEM_A;
    logic [31:0] MEM_DO;
    logic [3:0]  MEM_WE;
    logic        MEM_RD;
    logic [31:0] MEM_DI;
    logic [1:0]  GNT;

    sh_bus_arbiter #(.ROM_WAIT(2), .RAM_WAIT(1)) dut (
        .CLK(CLK), .RST(RST), .CE(CE),
        .M0_REQ(M0_REQ), .M0_A(M0_A), .M0_DO(M0_DO), .M0_WE(M0_WE),
        .M0_DI(M0_DI), .M0_WAIT(M0_WAIT),
        .M1_REQ(M1_REQ), .M1_A(M1_A), .M1_DO(M1_DO), .M1_WE(M1_WE),
        .M1_DI(M1_DI), .M1_WAIT(M1_WAIT),
`ifdef SH_ARB_LOCK_EN
        .M0_LOCK(M0_LOCK), .M1_LOCK(M1_LOCK),
`endif
        .MEM_A(MEM_A), .MEM_DO(MEM_DO), .MEM_WE(MEM_WE), .MEM_RD(MEM_RD),
        .MEM_DI(MEM_DI), .GNT(GNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        int          m;
        logic [31:0] di;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] di_model [2];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Compare a completed access (WAIT low in a CE cycle) against the oldest expectation.
    task automatic check_done(input int m);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: master %0d completed with no access pending", m);
        end else begin
            e = sb.pop_front();
            chk("done_master", 64'(m), 64'(e.m));
            chk("done_gnt", 64'(GNT), (m == 1) ? 64'd2 : 64'd1);
            chk("done_di", (m == 1) ? 64'(M1_DI) : 64'(M0_DI), 64'(e.di));
        end
    endtask

    // Monitor: pops the scoreboard whenever a master is released.
    always @(negedge CLK) begin
        if (!RST && CE) begin
            if (M0_REQ && !M0_WAIT) check_done(0);
            if (M1_REQ && !M1_WAIT) check_done(1);
        end
    end

    task automatic do_reset(input int n);
        RST = 1'b1;
        repeat (n) @(posedge CLK);
        #1;
        di_model[0] = '0;
        di_model[1] = '0;
    endtask

    task automatic run_access(input int m, input logic [26:0] a, input logic [31:0] d,
                              input logic [3:0] we, input logic [31:0] mdi, input bit ce_tog,
                              input int exp_done, input int exp_strb, input string nm);
        exp_t         e;
        int           done_k;
        int           strb;
        bit           ok;
        bit           prev_ce;
        logic [131:0] snap, snap_prev;
        e.m  = m;
        e.di = (we == 4'b0) ? mdi : di_model[m];
        di_model[m] = e.di;
        sb.push_back(e);
        MEM_DI = mdi;
        CE     = !ce_tog;
        if (m == 0) begin
            M0_A = a; M0_DO = d; M0_WE = we; M0_REQ = 1'b1;
        end else begin
            M1_A = a; M1_DO = d; M1_WE = we; M1_REQ = 1'b1;
        end
        done_k = 0; strb = 0; ok = 1'b1; prev_ce = 1'b1; snap_prev = '0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge CLK);
            snap = {GNT, MEM_A, MEM_DO, MEM_WE, MEM_RD, M0_DI, M1_DI, M0_WAIT, M1_WAIT};
            if (k > 1 && !prev_ce) chk({nm, "_ce_hold"}, 64'(snap == snap_prev), 64'd1);
            if (MEM_RD || MEM_WE != 4'b0) begin
                strb++;
                if (MEM_A != a || MEM_WE != we || MEM_RD != (we == 4'b0) ||
                    (we != 4'b0 && MEM_DO != d) || GNT != ((m == 1) ? 2'b10 : 2'b01))
                    ok = 1'b0;
            end
            if (CE && ((m == 0) ? !M0_WAIT : !M1_WAIT)) done_k = k;
            snap_prev = snap;
            prev_ce   = CE;
            @(posedge CLK);
            #1;
            if (done_k != 0) break;
            if (ce_tog) CE = !CE;
        end
        M0_REQ = 1'b0;
        M1_REQ = 1'b0;
        CE     = 1'b1;
        chk({nm, "_latency"}, 64'(done_k), 64'(exp_done));
        chk({nm, "_strobe_cycles"}, 64'(strb), 64'(exp_strb));
        chk({nm, "_strobe_fields"}, 64'(ok), 64'd1);
    endtask

    // Both masters requesting back to back; pat[i] is the expected owner of access i.
    task automatic run_contend(input int n, input logic [7:0] pat, input bit lock_mode,
                               input string nm);
        exp_t e;
        int   cnt;
        bit   both_low;
        bit   hit;
        for (int i = 0; i < n; i++) begin
            e.m  = int'(pat[i]);
            e.di = 32'hA000_0000 + 32'(i);
            di_model[e.m] = e.di;
            sb.push_back(e);
        end
        MEM_DI = 32'hA000_0000;
        cnt = 0; both_low = 1'b0;
        for (int k = 1; k <= 100; k++) begin
            @(negedge CLK);
            if (!M0_WAIT && !M1_WAIT) both_low = 1'b1;
            hit = CE && (!M0_WAIT || !M1_WAIT);
            @(posedge CLK);
            #1;
            if (hit) begin
                cnt++;
                MEM_DI = 32'hA000_0000 + 32'(cnt);
`ifdef SH_ARB_LOCK_EN
                if (lock_mode && cnt == 1) M0_LOCK = 1'b0;
`endif
                if (cnt == n) break;
            end
        end
        M0_REQ = 1'b0;
        M1_REQ = 1'b0;
        chk({nm, "_completions"}, 64'(cnt), 64'(n));
        chk({nm, "_wait_exclusive"}, 64'(both_low), 64'd0);
        if (lock_mode) chk({nm, "_lock_mode"}, 64'(lock_mode), 64'd1);
    endtask

    initial begin
        RST = 1'b1; CE = 1'b1;
        M0_REQ = 1'b0; M0_A = '0; M0_DO = '0; M0_WE = '0;
        M1_REQ = 1'b0; M1_A = '0; M1_DO = '0; M1_WE = '0;
        MEM_DI = '0;
`ifdef SH_ARB_LOCK_EN
        M0_LOCK = 1'b0; M1_LOCK = 1'b0;
`endif
        di_model[0] = '0;
        di_model[1] = '0;

        // Reset state
        do_reset(2);
        @(negedge CLK);
        chk("rst_gnt", 64'(GNT), 64'd0);
        chk("rst_mem_rd", 64'(MEM_RD), 64'd0);
        chk("rst_mem_we", 64'(MEM_WE), 64'd0);
        chk("rst_mem_a", 64'(MEM_A), 64'd0);
        chk("rst_mem_do", 64'(MEM_DO), 64'd0);
        chk("rst_m0_wait", 64'(M0_WAIT), 64'd0);
        chk("rst_m1_wait", 64'(M1_WAIT), 64'd0);
        chk("rst_m0_di", 64'(M0_DI), 64'd0);
        chk("rst_m1_di", 64'(M1_DI), 64'd0);
        @(posedge CLK);
        #1;
        RST = 1'b0;

        // Single-master accesses: ROM = 2 waits (done cycle 5), RAM = 1 wait (done cycle 4)
        run_access(0, 27'h0000100, 32'h0, 4'b0000, 32'h1234_5678, 1'b0, 5, 3, "m0_rom_rd");
        run_access(1, 27'h0004020, 32'hCAFE_BABE, 4'b0011, 32'hFFFF_0000, 1'b0, 4, 2, "m1_ram_wr");
        run_access(0, 27'h0003FFC, 32'h0, 4'b0000, 32'h0BAD_F00D, 1'b0, 5, 3, "m0_rom_edge");
        run_access(1, 27'h0004000, 32'h0, 4'b0000, 32'h55AA_55AA, 1'b0, 4, 2, "m1_ram_edge");
        run_access(0, 27'h7FFFFFC, 32'h0102_0304, 4'b1100, 32'hEEEE_EEEE, 1'b0, 4, 2, "m0_ram_wr");
        // CE low every other cycle: 4 CE cycles become 8 clocks
        run_access(0, 27'h0004100, 32'h0, 4'b0000, 32'h8765_4321, 1'b1, 8, 4, "m0_ce_rd");

        // Reset in the middle of a write drops strobes and grant
        M1_A = 27'h0000010; M1_DO = 32'h1111_1111; M1_WE = 4'b1111; M1_REQ = 1'b1;
        @(posedge CLK);
        #1;
        @(negedge CLK);
        chk("mid_we_active", 64'(MEM_WE), 64'hF);
        @(posedge CLK);
        #1;
        do_reset(1);
        @(negedge CLK);
        chk("mid_rst_gnt", 64'(GNT), 64'd0);
        chk("mid_rst_we", 64'(MEM_WE), 64'd0);
        chk("mid_rst_rd", 64'(MEM_RD), 64'd0);
        @(posedge CLK);
        #1;
        M1_REQ = 1'b0;
        RST = 1'b0;

        // Contention held from reset alternates M0, M1, M0, M1
        M0_A = 27'h0004000; M0_WE = 4'b0;
        M1_A = 27'h0004040; M1_WE = 4'b0;
        M0_REQ = 1'b1; M1_REQ = 1'b1;
        do_reset(2);
        RST = 1'b0;
        run_contend(4, 8'b0000_1010, 1'b0, "rr");

`ifdef SH_ARB_LOCK_EN
        // M0 locks across two accesses, then M1 gets the bus
        M0_LOCK = 1'b1;
        M0_REQ = 1'b1; M1_REQ = 1'b1;
        do_reset(2);
        RST = 1'b0;
        run_contend(3, 8'b0000_0100, 1'b1, "lock");
        M0_LOCK = 1'b0;
`endif

        repeat (5) @(negedge CLK);
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global time bound
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, %0d checks, %0d errors", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
